// File: rtl/srl_fifo_if.sv
// One valid/ready stream carrying a data word and a packet-last marker.
// The FIFO uses the slave modport on its input side and the master modport on its output side.
interface srl_fifo_if #(
   parameter int WIDTH = 32
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             last;

   modport master (output valid, output data, output last, input  ready);
   modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/srl_fifo.sv
// Shift-register FIFO: per-bit SRL chains, read mux addressed by occupancy-1.
// Optional SRL_FIFO_OUTPUT_REG_EN adds a one-entry registered output stage (capacity DEPTH+1).
module srl_fifo #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 32,
   parameter int ALMOST_FULL  = DEPTH - 2,
   parameter int ALMOST_EMPTY = 2,
`ifdef SRL_FIFO_OUTPUT_REG_EN
   localparam int CNT_W       = $clog2(DEPTH + 2)
`else
   localparam int CNT_W       = $clog2(DEPTH + 1)
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   srl_fifo_if.slave        s_if,
   srl_fifo_if.master       m_if,
   output logic [CNT_W-1:0] count,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int SC_W = $clog2(DEPTH + 1);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SRL_FIFO_OUTPUT_REG_EN
   localparam int CAP  = DEPTH + 1;
`else
   localparam int CAP  = DEPTH;
`endif
   localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

   if (WIDTH < 1) begin : g_chk_width
      $error("srl_fifo: WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_chk_depth
      $error("srl_fifo: DEPTH must be >= 2");
   end
   if (ALMOST_FULL > DEPTH) begin : g_chk_af
      $error("srl_fifo: ALMOST_FULL must be <= DEPTH");
   end
   if (ALMOST_EMPTY >= DEPTH) begin : g_chk_ae
      $error("srl_fifo: ALMOST_EMPTY must be < DEPTH");
   end

   // Chain storage has no reset and survives flush; only occupancy is cleared.
   logic [WIDTH:0]   srl_q [DEPTH] = '{default: '0};

   logic [SC_W-1:0]  sc_q, sc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic             af_q, af_d;
   logic             ae_q, ae_d;

   logic             clr;
   logic             push;
   logic             srl_pop;
   logic [SC_W-1:0]  rd_idx;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH:0]   rd_word;

   assign clr     = reset | flush;
   assign push    = s_if.valid & s_ready_q;
   assign rd_idx  = (sc_q == '0) ? '0 : sc_q - SC_ONE;
   assign rd_addr = rd_idx[AW-1:0];
   assign rd_word = srl_q[rd_addr];

   always_ff @(posedge clk) begin
      if (push && !clr) begin
         srl_q[0] <= {s_if.last, s_if.data};
         for (int i = DEPTH - 1; i > 0; i--) begin
            srl_q[i] <= srl_q[i-1];
         end
      end
   end

`ifdef SRL_FIFO_OUTPUT_REG_EN
   logic [WIDTH:0] out_q = '0;

   // Refill whenever the stage is empty or being drained this cycle.
   assign srl_pop = (sc_q != '0) & (~m_valid_q | m_if.ready);

   always_ff @(posedge clk) begin
      if (srl_pop && !clr) begin
         out_q <= rd_word;
      end
   end

   assign m_if.data = out_q[WIDTH-1:0];
   assign m_if.last = out_q[WIDTH];
`else
   assign srl_pop   = m_valid_q & m_if.ready;
   assign m_if.data = rd_word[WIDTH-1:0];
   assign m_if.last = rd_word[WIDTH];
`endif

   // Reset and flush both collapse to the empty state through the next-state logic.
   always_comb begin
      sc_d = sc_q;
      if (clr) begin
         sc_d = '0;
      end else begin
         case ({push, srl_pop})
            2'b10:   sc_d = sc_q + SC_ONE;
            2'b01:   sc_d = sc_q - SC_ONE;
            default: sc_d = sc_q;
         endcase
      end
`ifdef SRL_FIFO_OUTPUT_REG_EN
      m_valid_d = 1'b0;
      if (!clr) begin
         m_valid_d = srl_pop | (m_valid_q & ~m_if.ready);
      end
      cnt_d = CNT_W'(sc_d) + CNT_W'(m_valid_d);
`else
      cnt_d     = CNT_W'(sc_d);
      m_valid_d = (cnt_d != '0);
`endif
      s_ready_d = (cnt_d != CNT_W'(CAP));
      af_d      = (cnt_d >= CNT_W'(ALMOST_FULL));
      ae_d      = (cnt_d <= CNT_W'(ALMOST_EMPTY));
   end

   always_ff @(posedge clk) begin
      sc_q      <= sc_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
   end

   assign s_if.ready   = s_ready_q;
   assign m_if.valid   = m_valid_q;
   assign count        = cnt_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

endmodule

// File: doc/srl_fifo.md
Name: srl_fifo

Overview:
- Parametrised shift-register FIFO: data shifts into per-bit SRL chains; the read side is a mux addressed by current occupancy.
- Valid/ready stream handshake on both sides, full DEPTH capacity, occupancy count, almost-full/almost-empty flags, packet-last sideband and synchronous flush.
- Sits between wiphy stream stages (e.g. FFT, demapper) as the standard small elastic buffer.

Parameters:
- WIDTH, 32, data bits per entry (>=1).
- DEPTH, 32, entries stored (>=2; need not be a power of two).
- ALMOST_FULL, DEPTH-2, almost_full asserted when count >= ALMOST_FULL.
- ALMOST_EMPTY, 2, almost_empty asserted when count <= ALMOST_EMPTY.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all stored entries.
- s_valid  in  1  input beat valid.
- s_ready  out  1  FIFO can accept a beat.
- s_data  in  WIDTH  input data.
- s_last  in  1  input packet-last marker, stored alongside data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH  output data, oldest entry.
- m_last  out  1  last marker of oldest entry.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= ALMOST_FULL.
- almost_empty  out  1  count <= ALMOST_EMPTY.

Behaviour:
- Clocking: clk is the clock; reset is synchronous, active-high.
- push = s_valid & s_ready. pop = m_valid & m_ready.
- Storage: WIDTH+1 chains of DEPTH bits (data plus last). On push, every chain shifts by one and the new bit enters position 0. Chain contents have no reset, are initialised to 0 for simulation, and are not cleared by flush.
- Read address = count-1, clamped to 0 when count=0. m_data/m_last = chain[addr]. Read is combinational from registered state only; there is no combinational path from s_* or m_ready to any output.
- count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Shift and pop coincide, so addr is unchanged and the next-oldest entry appears.
  - neither: unchanged.
- s_ready, m_valid, almost_full and almost_empty are registers computed from next count:
  - s_ready = (next != DEPTH)
  - m_valid = (next != 0)
  - almost_full = (next >= ALMOST_FULL)
  - almost_empty = (next <= ALMOST_EMPTY)
- Latency: a beat pushed into an empty FIFO in cycle N presents m_valid=1 in cycle N+1. No fall-through.
- Full: s_ready=0. A pop while full raises s_ready in the next cycle; a push is never accepted in the same cycle as the pop that frees the slot.
- Empty: m_valid=0, and m_data holds chain[0] (don't-care). A pop cannot occur when empty.
- Simultaneous push and pop at count=1: count stays 1, the new beat is output next cycle, m_valid stays 1.
- flush (reset not asserted): next count=0, s_ready=1, m_valid=0, almost_full=(ALMOST_FULL==0), almost_empty=1. Any push or pop in the flush cycle is discarded and has no effect on count. flush has priority over push/pop.
- reset has priority over flush and gives the same values as flush.
- Reset values: count=0, s_ready=1, m_valid=0, almost_full=(ALMOST_FULL==0), almost_empty=1.
- Reset mid-transfer drops all contents. The first push after reset is output in the cycle after acceptance.
- Elaboration assertions: DEPTH >= 2, ALMOST_FULL <= DEPTH, ALMOST_EMPTY < DEPTH.

Optional Feature:
- Macro: SRL_FIFO_OUTPUT_REG_EN.
- Defined:
  - Adds a registered output stage (one entry) after the SRL read mux, so m_data/m_last/m_valid come directly from flops. This improves timing into wide downstream logic.
  - Total capacity becomes DEPTH+1.
  - Empty-to-output latency becomes 2 cycles.
  - The stage refills from the SRL whenever it is empty or popped. Back-to-back throughput of 1 beat/cycle is preserved.
  - count includes the output stage; its width becomes $clog2(DEPTH+2).
  - almost_full and almost_empty thresholds apply to this total count.
  - flush and reset also clear the stage's valid bit.
- Undefined: behaviour exactly as specified above.

Test Plan:
- Fill/drain, WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 with m_ready=0 -> s_ready=0 after 4th push, count=4, almost_full=1 (ALMOST_FULL=2). Then m_ready=1 -> outputs 0x11..0x44 in order, m_valid=0 and count=0 after the last pop.
- Latency: push 0xA5 into empty FIFO at cycle N -> m_valid=1 and m_data=0xA5 at N+1; with the macro defined, at N+2.
- Streaming: s_valid=1 and m_ready=1 continuously for 100 beats of an incrementing pattern -> 1 beat/cycle after the first, count stays 1, output sequence matches input.
- Full plus pop: count=4, pop with s_valid=1 -> no push that cycle, s_ready=1 next cycle, push accepted, count back to 4.
- Flush/reset: count=3, assert flush with s_valid=1 and m_ready=1 -> next cycle count=0, m_valid=0, s_ready=1. Push 0x5A -> 0x5A output, not stale data. Repeat with reset: same result.
- Last sideband: push 3 beats with s_last=0,0,1 under random m_ready backpressure -> m_last=1 only on the 3rd beat output.
